// File: rtl/binsearch_ctrl.sv
// Binary-search controller over an ascending-sorted, registered-address RAM.
// One probe every three cycles (CALC -> FETCH -> COMPARE); result held until en falls.
module binsearch_ctrl #(
    parameter int VAL_WIDTH  = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic [VAL_WIDTH-1:0]  A,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [VAL_WIDTH-1:0]  ram_q,
    output logic                  F,
    output logic                  NF,
    output logic [ADDR_WIDTH-1:0] F_addr,
    output logic                  done,
    output logic                  hex_en,
    output logic [2:0]            state_dbg
);

    // Request/response: a rising level on en (seen in IDLE) starts one search;
    // done rises with exactly one of F/NF and everything holds until en is low.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CALC    = 3'd1,
        FETCH   = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] lo, lo_n, hi, hi_n;
    logic [ADDR_WIDTH-1:0] ram_addr_n, f_addr_n;
    logic [VAL_WIDTH-1:0]  a_r, a_r_n;
    logic                  f_n, nf_n, done_n, hex_en_n;

    // One extra bit keeps lo+hi from overflowing before the halving.
    logic [ADDR_WIDTH:0]   sum;
    logic [ADDR_WIDTH-1:0] mid;

    assign sum       = {1'b0, lo} + {1'b0, hi};
    assign mid       = sum[ADDR_WIDTH:1];
    assign state_dbg = state;

    always_comb begin
        state_n    = state;
        lo_n       = lo;
        hi_n       = hi;
        a_r_n      = a_r;
        ram_addr_n = ram_addr;
        f_n        = F;
        nf_n       = NF;
        f_addr_n   = F_addr;
        done_n     = done;
        hex_en_n   = hex_en;
        unique case (state)
            IDLE: begin
                if (en) begin
                    a_r_n    = A;
                    lo_n     = '0;
                    hi_n     = '1;
                    f_n      = 1'b0;
                    nf_n     = 1'b0;
                    done_n   = 1'b0;
                    hex_en_n = 1'b0;
                    f_addr_n = '0;
                    state_n  = CALC;
                end
            end
            CALC: begin
                ram_addr_n = mid;
                state_n    = FETCH;
            end
            FETCH: begin
                state_n = COMPARE;
            end
            COMPARE: begin
                if (ram_q == a_r) begin
                    f_n      = 1'b1;
                    f_addr_n = ram_addr;
                    hex_en_n = 1'b1;
                    done_n   = 1'b1;
                    state_n  = DONE;
                end else if (ram_q < a_r) begin
                    // Probing the upper bound and still too small: nothing left to the right.
                    if (ram_addr == hi) begin
                        nf_n    = 1'b1;
                        done_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        lo_n    = ram_addr + ADDR_WIDTH'(1);
                        state_n = CALC;
                    end
                end else begin
                    if (ram_addr == lo) begin
                        nf_n    = 1'b1;
                        done_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        hi_n    = ram_addr - ADDR_WIDTH'(1);
                        state_n = CALC;
                    end
                end
            end
            DONE: begin
                // F_addr is deliberately kept so the display can still show it.
                if (!en) begin
                    f_n      = 1'b0;
                    nf_n     = 1'b0;
                    done_n   = 1'b0;
                    hex_en_n = 1'b0;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            lo       <= '0;
            hi       <= '1;
            a_r      <= '0;
            ram_addr <= '0;
            F        <= 1'b0;
            NF       <= 1'b0;
            F_addr   <= '0;
            done     <= 1'b0;
            hex_en   <= 1'b0;
        end else begin
            state    <= state_n;
            lo       <= lo_n;
            hi       <= hi_n;
            a_r      <= a_r_n;
            ram_addr <= ram_addr_n;
            F        <= f_n;
            NF       <= nf_n;
            F_addr   <= f_addr_n;
            done     <= done_n;
            hex_en   <= hex_en_n;
        end
    end

endmodule

// File: tb/tb_binsearch_ctrl.sv
// Self-checking bench for binsearch_ctrl: registered-address RAM model, directed
// corner searches, reset mid-search, and randomized keys over fixed and random sorted RAMs.
module tb_binsearch_ctrl;

    localparam int VW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset;
    logic          en;
    logic [VW-1:0] A;
    logic [VW-1:0] ram_q;
    logic [AW-1:0] ram_addr;
    logic [AW-1:0] F_addr;
    logic          F, NF, done, hex_en;
    logic [2:0]    state_dbg;

    logic [VW-1:0] mem [DEPTH];

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [AW:0]   exp_q[$];

    binsearch_ctrl #(.VAL_WIDTH(VW), .ADDR_WIDTH(AW)) dut (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .A         (A),
        .ram_addr  (ram_addr),
        .ram_q     (ram_q),
        .F         (F),
        .NF        (NF),
        .F_addr    (F_addr),
        .done      (done),
        .hex_en    (hex_en),
        .state_dbg (state_dbg)
    );

    // Clock and registered-address RAM
    always #10 clock = ~clock;
    always @(posedge clock) ram_q <= mem[ram_addr];

    // Reference: plain-integer binary search following the lo/hi/mid rules.
    function automatic void model_search(input logic [VW-1:0] key, output logic found,
                                         output int idx, output int probes);
        int lo, hi, mid;
        lo = 0; hi = DEPTH - 1; found = 1'b0; idx = 0; probes = 0;
        for (int p = 0; p < DEPTH; p++) begin
            mid = (lo + hi) / 2;
            probes++;
            if (mem[mid] == key) begin
                found = 1'b1; idx = mid; return;
            end else if (mem[mid] < key) begin
                if (mid == hi) return;
                lo = mid + 1;
            end else begin
                if (mid == lo) return;
                hi = mid - 1;
            end
        end
    endfunction

    // Driver + checker for one search. Called at a negedge with the DUT idle and en low.
    // change_at/drop_at are edge numbers (edge 0 = the edge that first samples en high).
    task automatic run_search(input string name, input logic [VW-1:0] key,
                              input logic [VW-1:0] key2, input int change_at,
                              input int drop_at, input int hold_cycles, input int fixed_idx);
        logic        found;
        int          idx, probes, c;
        logic [AW:0] exp;
        logic        ef;
        model_search(key, found, idx, probes);
        exp_q.push_back({found, AW'(idx)});
        A  = key;
        en = 1'b1;
        c  = 0;
        while (c < 3 * (AW + 1) + 6) begin
            @(negedge clock);
            c++;
            if (done === 1'b1) break;
            if (c - 1 == change_at) A = key2;
            if (c - 1 == drop_at) en = 1'b0;
        end
        exp = exp_q.pop_front();
        ef  = exp[AW];
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s timeout: done=%b after %0d edges, required 1 after %0d", name, done, c, 3 * probes);
        end else if (c - 1 != 3 * probes) begin
            n_fail++;
            $display("FAIL %s latency: done after edge %0d, required edge %0d", name, c - 1, 3 * probes);
        end
        n_checks++;
        if (probes > AW + 1) begin
            n_fail++;
            $display("FAIL %s probe_bound: %0d probes, required <= %0d", name, probes, AW + 1);
        end
        n_checks++;
        if ({F, NF, hex_en} !== {ef, ~ef, ef}) begin
            n_fail++;
            $display("FAIL %s flags: F/NF/hex_en=%b%b%b, required %b%b%b", name, F, NF, hex_en, ef, ~ef, ef);
        end
        n_checks++;
        if (ef && fixed_idx >= 0 && F_addr !== AW'(fixed_idx)) begin
            n_fail++;
            $display("FAIL %s F_addr: got %0d, required %0d", name, F_addr, fixed_idx);
        end else if (ef && mem[F_addr] !== key) begin
            n_fail++;
            $display("FAIL %s F_addr_match: mem[%0d]=%0d, required key %0d", name, F_addr, mem[F_addr], key);
        end else if (!ef && F_addr !== '0) begin
            n_fail++;
            $display("FAIL %s F_addr_clear: got %0d, required 0", name, F_addr);
        end
        for (int h = 0; h < hold_cycles && en; h++) begin
            @(negedge clock);
            n_checks++;
            if ({F, NF, done, hex_en} !== {ef, ~ef, 1'b1, ef} || (ef && mem[F_addr] !== key)) begin
                n_fail++;
                $display("FAIL %s hold%0d: F/NF/done/hex_en=%b%b%b%b F_addr=%0d, required %b%b1%b", name, h,
                         F, NF, done, hex_en, F_addr, ef, ~ef, ef);
            end
        end
        en = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({F, NF, done, hex_en} !== 4'b0000) begin
            n_fail++;
            $display("FAIL %s release: F/NF/done/hex_en=%b%b%b%b, required 0000", name, F, NF, done, hex_en);
        end
        n_checks++;
        if ((ef && mem[F_addr] !== key) || (!ef && F_addr !== '0)) begin
            n_fail++;
            $display("FAIL %s keep_F_addr: got %0d after release", name, F_addr);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; A = 8'd30;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({F, NF, done, hex_en} !== 4'b0000 || F_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: F/NF/done/hex_en=%b%b%b%b F_addr=%0d, required 0000 0", F, NF, done, hex_en, F_addr);
        end
        n_checks++;
        if (ram_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_ram_addr: got %0d, required 0", ram_addr);
        end
        reset = 1'b0;
        // en still high: the search must begin on the first edge after release.
        run_search("reset_release_A30", 8'd30, 8'd30, -1, -1, 0, 15);
    endtask

    task automatic test_directed();
        run_search("hit_mid_A30", 8'd30, 8'd30, -1, -1, 0, 15);
        run_search("low_end_A0", 8'd0, 8'd0, -1, -1, 0, 0);
        run_search("high_end_A62", 8'd62, 8'd62, -1, -1, 0, 31);
        run_search("absent_A31", 8'd31, 8'd31, -1, -1, 0, -1);
        run_search("above_A200", 8'd200, 8'd200, -1, -1, 0, -1);
    endtask

    task automatic test_key_change();
        run_search("key_change_A20", 8'd20, 8'd40, 2, 5, 0, 10);
    endtask

    task automatic test_reset_mid();
        int c;
        A = 8'd62; en = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if ({F, NF, done, hex_en} !== 4'b0000 || F_addr !== '0 || ram_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: F/NF/done/hex_en=%b%b%b%b F_addr=%0d ram_addr=%0d, required all 0",
                     F, NF, done, hex_en, F_addr, ram_addr);
        end
        reset = 1'b0;
        c = 0;
        while (c < 40) begin
            @(negedge clock);
            c++;
            if (done === 1'b1) break;
        end
        n_checks++;
        if (done !== 1'b1 || c - 1 != 18 || F !== 1'b1 || F_addr !== 5'd31) begin
            n_fail++;
            $display("FAIL reset_mid_restart: done=%b edge=%0d F=%b F_addr=%0d, required 1 18 1 31", done, c - 1, F, F_addr);
        end
        en = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        run_search("b2b_hold_A44", 8'd44, 8'd44, -1, -1, 10, 22);
        run_search("b2b_hold_A7", 8'd7, 8'd7, -1, -1, 10, -1);
        run_search("b2b_next_A2", 8'd2, 8'd2, -1, -1, 0, 1);
    endtask

    task automatic test_random();
        logic [VW-1:0] k;
        for (int i = 0; i < 16; i++) begin
            k = VW'($urandom_range(0, 255));
            run_search("rand_fixed", k, VW'($urandom_range(0, 255)), 2, -1, 0, -1);
        end
        mem[0] = VW'($urandom_range(0, 3));
        for (int i = 1; i < DEPTH; i++) mem[i] = mem[i-1] + VW'($urandom_range(0, 7));
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) k = mem[$urandom_range(0, DEPTH - 1)];
            else k = VW'($urandom_range(0, 255));
            run_search("rand_sorted", k, k, -1, -1, 0, -1);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = VW'(2 * i);
        reset = 1'b1; en = 1'b0; A = '0;
        @(negedge clock);
        test_reset();
        test_directed();
        test_key_change();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/binsearch_ctrl.md
BINSEARCH_CTRL -- requirements
Module: binsearch_ctrl

Interface
REQ-001 SHALL have parameter VAL_WIDTH, default 8, the width of each RAM word and of the search key.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, the RAM address width; search depth is 2^ADDR_WIDTH words.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: level start/hold request (switch-driven).
REQ-006 SHALL have port A, input, VAL_WIDTH bits: search key.
REQ-007 SHALL have port ram_addr, output, ADDR_WIDTH bits: registered RAM read address.
REQ-008 SHALL have port ram_q, input, VAL_WIDTH bits: RAM read data, valid one edge after ram_addr is sampled by the RAM (registered-address RAM).
REQ-009 SHALL have port F, output, 1 bit: key found.
REQ-010 SHALL have port NF, output, 1 bit: key not found.
REQ-011 SHALL have port F_addr, output, ADDR_WIDTH bits: index of the match.
REQ-012 SHALL have port done, output, 1 bit: search complete.
REQ-013 SHALL have port hex_en, output, 1 bit: display enable for F_addr.

Function
REQ-014 SHALL implement the FSM states IDLE, CALC, FETCH, COMPARE and DONE, with all outputs registered.
REQ-015 In IDLE with en=1, the block SHALL latch A into A_r, set lo=0 and hi=2^ADDR_WIDTH-1, clear F/NF/done/hex_en/F_addr, and go to CALC; with en=0 it SHALL stay in IDLE.
REQ-016 In CALC, the block SHALL set ram_addr <= (lo+hi)>>1, computed with ADDR_WIDTH+1 bits so there is no overflow, and go to FETCH.
REQ-017 In FETCH, the block SHALL hold ram_addr as the RAM wait cycle and go to COMPARE.
REQ-018 COMPARE, ram_q==A_r: the block SHALL set F=1, F_addr=ram_addr, hex_en=1 and done=1, and go to DONE.
REQ-019 COMPARE, ram_q<A_r: if ram_addr==hi the block SHALL set NF=1 and done=1 and go to DONE; otherwise it SHALL set lo=ram_addr+1 and go to CALC.
REQ-020 COMPARE, ram_q>A_r: if ram_addr==lo the block SHALL set NF=1 and done=1 and go to DONE; otherwise it SHALL set hi=ram_addr-1 and go to CALC. These guards SHALL prevent wrap-around at index 0 and at index 2^ADDR_WIDTH-1.
REQ-021 Comparisons SHALL be unsigned; RAM contents are ascending-sorted. With duplicate values, any matching index is acceptable.
REQ-022 The block SHALL take 3 cycles per probe; with en sampled high at edge 0, done SHALL be high after edge 3n for a result on probe n, and n <= ADDR_WIDTH+1.
REQ-023 F and NF SHALL be mutually exclusive, and done SHALL equal F|NF.
REQ-024 A changing during a search SHALL be ignored because A_r is used; en dropping mid-search SHALL NOT abort it.
REQ-025 In DONE, the block SHALL hold all outputs while en=1; on en=0 it SHALL clear F/NF/done/hex_en, keep F_addr, and go to IDLE. A new search SHALL require en to fall and then rise again.
REQ-026 hex_en SHALL be high only while F=1.

Reset
REQ-027 reset=1 at any edge, including mid-search, SHALL force IDLE, lo=0, hi=all ones, ram_addr=0, A_r=0, and F=NF=done=hex_en=0, F_addr=0.
REQ-028 reset SHALL take priority over en; after release, a held en=1 SHALL start a search on the next edge.

Verification (RAM model: registered address, mem[i]=2*i, i=0..31)
REQ-029 A=30, en 0->1 -> first probe at addr 15 hits; F=1, F_addr=15, hex_en=1, done=1 after edge 3.
REQ-030 A=0 -> F=1, F_addr=0 after 5 probes; A=62 -> F=1, F_addr=31 after 6 probes; no address wrap at either end.
REQ-031 A=31 (odd, absent) -> NF=1, F=0, hex_en=0, done=1 within 18 cycles; A=200 -> NF=1 after probe at addr 31.
REQ-032 Search for A=20 with A changed to 40 after edge 2 -> F=1, F_addr=10.
REQ-033 reset pulsed during FETCH -> next cycle all outputs 0, state IDLE; the search restarts with en held high and completes correctly.
REQ-034 After done, en held high -> outputs stable for 10 cycles; en low -> F/NF/done clear on the next edge; en high -> a new search runs.
